// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per clock,
// eight registered BCD digits plus sign/overflow held stable between conversions.
module bcd_seq_converter #(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        done,
  output logic        neg,
  output logic        ovf,
  output logic [31:0] bcd_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_shift;
  logic [39:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_pend_neg;
  logic        r_in_ready;
  logic        r_done;
  logic        r_neg;
  logic        r_ovf;
  logic [31:0] r_bcd;

  logic [39:0] w_acc_adj;
  logic [39:0] w_acc_next;
  logic [31:0] w_shift_next;
  logic [31:0] w_mag;
  logic        w_neg_in;

  // Add 3 to every digit of 5 or more so the following shift carries correctly.
  function automatic logic [39:0] add3_adjust(input logic [39:0] acc);
    logic [39:0] res;
    res = acc;
    for (int i = 0; i < 10; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

  // Iteration datapath and input magnitude/sign extraction.
  always_comb begin
    w_acc_adj    = add3_adjust(r_acc);
    w_acc_next   = {w_acc_adj[38:0], r_shift[31]};
    w_shift_next = {r_shift[30:0], 1'b0};
    if (SIGNED_IN && in_data[31]) begin
      w_mag    = ~in_data + 32'd1;
      w_neg_in = 1'b1;
    end else begin
      w_mag    = in_data;
      w_neg_in = 1'b0;
    end
  end

  // Control FSM; the last iteration is registered straight into the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= 32'd0;
      r_acc      <= 40'd0;
      r_cnt      <= 5'd0;
      r_pend_neg <= 1'b0;
      r_in_ready <= 1'b1;
      r_done     <= 1'b0;
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd      <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (in_valid) begin
            r_shift    <= w_mag;
            r_pend_neg <= w_neg_in;
            r_acc      <= 40'd0;
            r_cnt      <= 5'd0;
            r_in_ready <= 1'b0;
            r_state    <= CONV;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        CONV: begin
          r_acc   <= w_acc_next;
          r_shift <= w_shift_next;
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_bcd   <= w_acc_next[31:0];
            r_ovf   <= |w_acc_next[39:32];
            r_neg   <= r_pend_neg;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_done <= 1'b0;
          end
        end
        DONE: begin
          r_done     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_done     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign done     = r_done;
  assign neg      = r_neg;
  assign ovf      = r_ovf;
  assign bcd_out  = r_bcd;

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential binary-to-BCD controller for the seven-segment output path.
- Accepts a 32-bit word over a valid/ready handshake and converts it with an iterative shift-add-3 (double-dabble) sequence, one bit per clock.
- Registers eight BCD digits plus sign and overflow flags; these hold stable between conversions.
- Drives the eight display decoders with one shared, time-sequenced converter, replacing a wide combinational converter.

Parameters:
- SIGNED_IN, 1: 1 = input is two's complement (magnitude plus neg flag); 0 = input is unsigned, and neg is always 0.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_data  in  32  binary value to convert.
- in_ready  out  1  converter is idle and can accept a value.
- done  out  1  one-cycle pulse: new result registered.
- neg  out  1  sign of the last converted value.
- ovf  out  1  magnitude of the last value is 100,000,000 or greater (does not fit in 8 digits).
- bcd_out  out  32  eight BCD digits; digit i is bcd_out[4i+3:4i]; digit 0 is the units digit.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, in_ready = 1, done = 0, neg = 0, ovf = 0, bcd_out = 0, iteration counter = 0.
  - Reset overrides everything, including a conversion in progress. No done pulse is produced and outputs clear to 0 on the reset edge.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - At an edge with in_valid = 1 (edge E0):
    - latch the magnitude into a 32-bit shift register;
    - latch the sign into a pending-neg register;
    - clear the 40-bit BCD accumulator (10 digits);
    - counter = 0; go to CONV.
  - Magnitude rule:
    - SIGNED_IN = 1 and in_data[31] = 1: magnitude = (~in_data + 1), taken as an unsigned 32-bit value. 0x80000000 gives 2,147,483,648 with no special case.
    - Otherwise magnitude = in_data.
- CONV:
  - in_ready = 0. in_valid is ignored; values are neither queued nor dropped silently, because the handshake is not completed.
  - Each edge performs one iteration:
    - every accumulator digit of 5 or more gets +3;
    - then {accumulator, shift register} shifts left by 1, MSB of the shift register first.
  - The counter increments on each iteration.
  - Edge E32 performs the 32nd iteration (counter = 31). On that edge:
    - bcd_out = low 8 digits of the final accumulator;
    - ovf = 1 if either of the upper 2 digits is nonzero;
    - neg = pending-neg;
    - done = 1; state goes to DONE.
  - The final iteration result is formed combinationally and registered directly at E32, with no extra cycle.
- DONE:
  - done = 1 for exactly this cycle; in_ready = 0.
  - On the next edge (E33): done = 0, state = IDLE, in_ready = 1.
- Latency and throughput:
  - done is high in the cycle following E32 (32 cycles after the accept edge).
  - The earliest next accept is E34, so one conversion completes every 34 cycles with in_valid held high.
- Output hold:
  - bcd_out, neg and ovf change only at the completion edge or at reset.
  - During CONV they keep showing the previous result, so the displays never flicker with partial values.
- Overflow: bcd_out shows the low 8 decimal digits; digits are not saturated. Display of the overflow is the consumer's responsibility.
- Accumulator width: 40 bits, enough for 4,294,967,295 (10 digits). No digit ever exceeds 9 after an iteration.

Test Plan:
- Reset, then in_valid with in_data = 0:
  - in_ready drops the cycle after accept;
  - done pulses exactly 32 cycles after the accept edge;
  - bcd_out = 0x00000000, neg = 0, ovf = 0;
  - in_ready = 1 the cycle after done.
- in_data = 12,345,678 → bcd_out = 0x12345678, neg = 0, ovf = 0. Then in_data = 99,999,999 → 0x99999999, ovf = 0. Then 100,000,000 → 0x00000000, ovf = 1.
- SIGNED_IN = 1:
  - 0xFFFFFFFF → neg = 1, bcd_out = 0x00000001, ovf = 0.
  - 0x80000000 → neg = 1, bcd_out = 0x47483648, ovf = 1.
- SIGNED_IN = 0: 0xFFFFFFFF → neg = 0, bcd_out = 0x94967295, ovf = 1.
- in_valid held high with changing in_data:
  - accepts occur exactly every 34 cycles;
  - values presented during CONV/DONE are not accepted;
  - bcd_out holds the previous result until each done.
- Convert 12,345,678, then start a conversion of 5 and assert reset at the 10th CONV cycle:
  - next cycle: bcd_out = 0, neg = 0, ovf = 0, in_ready = 1, no done pulse;
  - a following conversion of 5 gives bcd_out = 0x00000005.
